maze_mover: RTL and testbench

Parametrised player-motion engine for the maze game; successor to the in-line movement logic in the game top level.
- Tracks player tile row/col and in-tile offset incrementally, so no divide or modulo is needed.
- Fetches wall bits for the current and adjacent tile through a shared req/ack lookup port, then applies collision rules with a per-level margin.
- Sits between the game-tick divider, buttons and level ROM mux on one side, and drawcon/game_fsm on the other.

---
 rtl/maze_mover.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_maze_mover.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_mover.sv
// maze_mover: incremental player-motion engine with a shared req/ack wall-lookup port.
// Build macro MAZE_MOVER_DIAG_EN additionally accepts diagonal (two orthogonal bit) moves.
module maze_mover #(
  parameter int POS_W      = 11,
  parameter int RC_W       = 5,
  parameter int OFF_W      = 10,
  parameter int STEP       = 2,
  parameter int SPRITE     = 10,
  parameter int START_ROW  = 0,
  parameter int START_COL  = 9,
  parameter int START_XOFF = 34,
  parameter int START_YOFF = 41,
  parameter int START_X    = 394,
  parameter int START_Y    = 41
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [3:0]       dir,
  input  logic             home,
  input  logic             level_restart,
  input  logic [OFF_W-1:0] tile_w,
  input  logic [OFF_W-1:0] tile_h,
  input  logic [RC_W-1:0]  num_rows,
  input  logic [RC_W-1:0]  num_cols,
  input  logic [OFF_W-1:0] wall_margin,
  output logic             wall_req,
  output logic [RC_W-1:0]  wall_row,
  output logic [RC_W-1:0]  wall_col,
  input  logic             wall_ack,
  input  logic [3:0]       walls,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [RC_W-1:0]  cur_row,
  output logic [RC_W-1:0]  cur_col,
  output logic             busy,
  output logic             moved,
  output logic             blocked
);
  // Lookup handshake: wall_req stays high with a stable address until a cycle with wall_ack=1; ack while wall_req=0 is ignored.

  typedef enum logic [1:0] {IDLE, RD_CUR, RD_ADJ, DECIDE} state_e;

  localparam int SW = OFF_W + 2;
  localparam logic [SW-1:0]    STEP_S   = SW'(STEP);
  localparam logic [SW-1:0]    SPR_S    = SW'(SPRITE);
  localparam logic [POS_W-1:0] STEP_P   = POS_W'(STEP);
  localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]  HOME_ROW = RC_W'(START_ROW);
  localparam logic [RC_W-1:0]  HOME_COL = RC_W'(START_COL);
  localparam logic [OFF_W-1:0] HOME_XO  = OFF_W'(START_XOFF);
  localparam logic [OFF_W-1:0] HOME_YO  = OFF_W'(START_YOFF);
  localparam logic [POS_W-1:0] HOME_X   = POS_W'(START_X);
  localparam logic [POS_W-1:0] HOME_Y   = POS_W'(START_Y);

  state_e           state_q, state_d;
  logic [3:0]       dir_q, dir_d, wc_q, wc_d, wa_q, wa_d;
  logic [RC_W-1:0]  row_q, row_d, col_q, col_d;
  logic [OFF_W-1:0] xoff_q, xoff_d, yoff_q, yoff_d;
  logic [POS_W-1:0] px_q, px_d, py_q, py_d;
  logic             moved_q, moved_d, blocked_q, blocked_d;
`ifdef MAZE_MOVER_DIAG_EN
  logic             axis_q, axis_d, acc_q, acc_d;
`endif

  logic [3:0] act_dir;
`ifdef MAZE_MOVER_DIAG_EN
  // axis_q=0 resolves the vertical component, axis_q=1 the horizontal one.
  assign act_dir = axis_q ? (dir_q & 4'b0110) : (dir_q & 4'b1001);
`else
  assign act_dir = dir_q;
`endif

  logic go_up, go_lf, go_rt, go_dn;
  assign go_up = act_dir[0];
  assign go_lf = act_dir[1];
  assign go_rt = act_dir[2];
  assign go_dn = act_dir[3];

  logic at_edge;
  assign at_edge = (go_up && (row_q == '0)) || (go_dn && (row_q == num_rows - RC_ONE)) ||
                   (go_lf && (col_q == '0)) || (go_rt && (col_q == num_cols - RC_ONE));

  logic [RC_W-1:0] adj_row, adj_col;
  assign adj_row = go_up ? row_q - RC_ONE : (go_dn ? row_q + RC_ONE : row_q);
  assign adj_col = go_lf ? col_q - RC_ONE : (go_rt ? col_q + RC_ONE : col_q);

  assign wall_req = (state_q == RD_CUR) || ((state_q == RD_ADJ) && !at_edge);
  assign wall_row = (state_q == RD_ADJ) ? adj_row : row_q;
  assign wall_col = (state_q == RD_ADJ) ? adj_col : col_q;

  logic [SW-1:0] x_ext, y_ext, tw_ext, th_ext, m_ext;
  assign x_ext  = {2'b00, xoff_q};
  assign y_ext  = {2'b00, yoff_q};
  assign tw_ext = {2'b00, tile_w};
  assign th_ext = {2'b00, tile_h};
  assign m_ext  = {2'b00, wall_margin};

  logic x_cross_r, x_cross_l, y_cross_d, y_cross_u;
  assign x_cross_r = (x_ext + STEP_S) >= tw_ext;
  assign x_cross_l = x_ext < STEP_S;
  assign y_cross_d = (y_ext + STEP_S) >= th_ext;
  assign y_cross_u = y_ext < STEP_S;

  // Margin added on the left side of the compare so a margin wider than the tile cannot underflow.
  logic wall_hit, edge_cross, step_blocked;
  assign wall_hit = (go_up && (wc_q[3] | wa_q[2]) && (y_ext <= m_ext)) ||
                    (go_dn && (wc_q[2] | wa_q[3]) && ((y_ext + SPR_S + m_ext) >= th_ext)) ||
                    (go_lf && (wc_q[1] | wa_q[0]) && (x_ext <= m_ext)) ||
                    (go_rt && (wc_q[0] | wa_q[1]) && ((x_ext + SPR_S + m_ext) >= tw_ext));
  assign edge_cross = at_edge && ((go_up && y_cross_u) || (go_dn && y_cross_d) ||
                                  (go_lf && x_cross_l) || (go_rt && x_cross_r));
  assign step_blocked = wall_hit || edge_cross;

  logic accept;
`ifdef MAZE_MOVER_DIAG_EN
  assign accept = $onehot(dir) || ($onehot(dir & 4'b1001) && $onehot(dir & 4'b0110));
`else
  assign accept = $onehot(dir);
`endif

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    wc_d      = wc_q;
    wa_d      = wa_q;
    row_d     = row_q;
    col_d     = col_q;
    xoff_d    = xoff_q;
    yoff_d    = yoff_q;
    px_d      = px_q;
    py_d      = py_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
`ifdef MAZE_MOVER_DIAG_EN
    axis_d    = axis_q;
    acc_d     = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tick && accept) begin
          dir_d   = dir;
          state_d = RD_CUR;
`ifdef MAZE_MOVER_DIAG_EN
          axis_d  = ~|(dir & 4'b1001);
          acc_d   = 1'b0;
`endif
        end
      end
      RD_CUR: begin
        if (wall_ack) begin
          wc_d    = walls;
          state_d = RD_ADJ;
        end
      end
      RD_ADJ: begin
        if (at_edge) begin
          wa_d    = 4'b1111;
          state_d = DECIDE;
        end else if (wall_ack) begin
          wa_d    = walls;
          state_d = DECIDE;
        end
      end
      DECIDE: begin
        if (!step_blocked) begin
          if (go_up) begin
            py_d = py_q - STEP_P;
            if (y_cross_u) begin
              row_d  = row_q - RC_ONE;
              yoff_d = OFF_W'(y_ext + th_ext - STEP_S);
            end else begin
              yoff_d = OFF_W'(y_ext - STEP_S);
            end
          end
          if (go_dn) begin
            py_d = py_q + STEP_P;
            if (y_cross_d) begin
              row_d  = row_q + RC_ONE;
              yoff_d = OFF_W'(y_ext + STEP_S - th_ext);
            end else begin
              yoff_d = OFF_W'(y_ext + STEP_S);
            end
          end
          if (go_lf) begin
            px_d = px_q - STEP_P;
            if (x_cross_l) begin
              col_d  = col_q - RC_ONE;
              xoff_d = OFF_W'(x_ext + tw_ext - STEP_S);
            end else begin
              xoff_d = OFF_W'(x_ext - STEP_S);
            end
          end
          if (go_rt) begin
            px_d = px_q + STEP_P;
            if (x_cross_r) begin
              col_d  = col_q + RC_ONE;
              xoff_d = OFF_W'(x_ext + STEP_S - tw_ext);
            end else begin
              xoff_d = OFF_W'(x_ext + STEP_S);
            end
          end
        end
`ifdef MAZE_MOVER_DIAG_EN
        if (!axis_q && |(dir_q & 4'b0110)) begin
          axis_d  = 1'b1;
          acc_d   = !step_blocked;
          state_d = RD_ADJ;
        end else begin
          moved_d   = acc_q | !step_blocked;
          blocked_d = !(acc_q | !step_blocked);
          state_d   = IDLE;
        end
`else
        moved_d   = !step_blocked;
        blocked_d = step_blocked;
        state_d   = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (level_restart || home) begin
      state_d   = IDLE;
      row_d     = HOME_ROW;
      col_d     = HOME_COL;
      xoff_d    = HOME_XO;
      yoff_d    = HOME_YO;
      px_d      = HOME_X;
      py_d      = HOME_Y;
      moved_d   = 1'b0;
      blocked_d = 1'b0;
`ifdef MAZE_MOVER_DIAG_EN
      axis_d    = 1'b0;
      acc_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      dir_q     <= 4'b0000;
      wc_q      <= 4'b0000;
      wa_q      <= 4'b0000;
      row_q     <= HOME_ROW;
      col_q     <= HOME_COL;
      xoff_q    <= HOME_XO;
      yoff_q    <= HOME_YO;
      px_q      <= HOME_X;
      py_q      <= HOME_Y;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
`ifdef MAZE_MOVER_DIAG_EN
      axis_q    <= 1'b0;
      acc_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      wc_q      <= wc_d;
      wa_q      <= wa_d;
      row_q     <= row_d;
      col_q     <= col_d;
      xoff_q    <= xoff_d;
      yoff_q    <= yoff_d;
      px_q      <= px_d;
      py_q      <= py_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
`ifdef MAZE_MOVER_DIAG_EN
      axis_q    <= axis_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign pos_x   = px_q;
  assign pos_y   = py_q;
  assign cur_row = row_q;
  assign cur_col = col_q;
  assign busy    = (state_q != IDLE);
  assign moved   = moved_q;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_maze_mover.sv
// tb_maze_mover: drives random and directed moves, compares against a pixel-level reference model.
module tb_maze_mover;
  localparam int STEP = 2;
  localparam int SPRITE = 10;
  localparam int HOME_X = 394;
  localparam int HOME_Y = 41;

  logic        clk, rst, tick, home, level_restart;
  logic [3:0]  dir, walls;
  logic [9:0]  tile_w, tile_h, wall_margin;
  logic [4:0]  num_rows, num_cols, wall_row, wall_col, cur_row, cur_col;
  logic        wall_req, wall_ack, busy, moved, blocked;
  logic [10:0] pos_x, pos_y;

  maze_mover dut (
    .clk(clk), .rst(rst), .tick(tick), .dir(dir), .home(home), .level_restart(level_restart),
    .tile_w(tile_w), .tile_h(tile_h), .num_rows(num_rows), .num_cols(num_cols),
    .wall_margin(wall_margin), .wall_req(wall_req), .wall_row(wall_row), .wall_col(wall_col),
    .wall_ack(wall_ack), .walls(walls), .pos_x(pos_x), .pos_y(pos_y), .cur_row(cur_row),
    .cur_col(cur_col), .busy(busy), .moved(moved), .blocked(blocked)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // wall map and lookup responder
  logic [3:0] wall_map [0:31][0:31];
  int ack_delay = 0;
  int req_age = 0;
  int n_req = 0;
  int bad_addr = 0;
  int addr_moves = 0;
  int max_age = 0;
  logic [4:0] held_row, held_col;

  initial begin
    wall_ack = 1'b0;
    walls = 4'h0;
    forever begin
      @(negedge clk);
      if (wall_ack) begin
        wall_ack = 1'b0;
        req_age = 0;
      end
      if (wall_req) begin
        if (req_age == 0) begin
          held_row = wall_row;
          held_col = wall_col;
          n_req++;
          if (wall_row >= num_rows || wall_col >= num_cols) bad_addr++;
        end else if (wall_row != held_row || wall_col != held_col) begin
          addr_moves++;
        end
        if (req_age >= ack_delay) begin
          wall_ack = 1'b1;
          walls = wall_map[wall_row][wall_col];
          max_age = req_age;
        end
        req_age++;
      end else begin
        req_age = 0;
      end
    end
  end

  int n_moved_seen = 0;
  always @(negedge clk) if (moved === 1'b1) n_moved_seen++;

  // reference model: absolute pixel position, tile coordinates derived by division
  int mx = HOME_X;
  int my = HOME_Y;
  int n_moved_exp = 0;

  task automatic model_step(input logic [3:0] d, output bit mv, output bit blk);
    int tw, th, m, row, col, xo, yo, ar, ac;
    bit off_grid, hit, off_cross;
    logic [3:0] wc, wa;
    tw = int'(tile_w); th = int'(tile_h); m = int'(wall_margin);
    row = my / th; col = mx / tw; xo = mx % tw; yo = my % th;
    ar = row; ac = col;
    hit = 0; off_cross = 0;
    case (d)
      4'b0001: ar = row - 1;
      4'b1000: ar = row + 1;
      4'b0010: ac = col - 1;
      4'b0100: ac = col + 1;
      default: ;
    endcase
    off_grid = (ar < 0) || (ar >= int'(num_rows)) || (ac < 0) || (ac >= int'(num_cols));
    wc = wall_map[row][col];
    if (off_grid) wa = 4'hf;
    else wa = wall_map[ar][ac];
    case (d)
      4'b0001: begin hit = (wc[3] | wa[2]) && (yo <= m);               off_cross = off_grid && (yo < STEP);       end
      4'b1000: begin hit = (wc[2] | wa[3]) && (yo + SPRITE >= th - m); off_cross = off_grid && (yo + STEP >= th); end
      4'b0010: begin hit = (wc[1] | wa[0]) && (xo <= m);               off_cross = off_grid && (xo < STEP);       end
      4'b0100: begin hit = (wc[0] | wa[1]) && (xo + SPRITE >= tw - m); off_cross = off_grid && (xo + STEP >= tw); end
      default: ;
    endcase
    blk = hit || off_cross;
    mv = !blk;
    if (mv) begin
      n_moved_exp++;
      case (d)
        4'b0001: my -= STEP;
        4'b1000: my += STEP;
        4'b0010: mx -= STEP;
        4'b0100: mx += STEP;
        default: ;
      endcase
    end
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_pos_x"}, 32'(pos_x), 32'(mx));
    check({tag, "_pos_y"}, 32'(pos_y), 32'(my));
    check({tag, "_row"}, 32'(cur_row), 32'(my / int'(tile_h)));
    check({tag, "_col"}, 32'(cur_col), 32'(mx / int'(tile_w)));
  endtask

  // driver tasks
  task automatic do_move(input logic [3:0] d, input bit extra, output int lat);
    bit exp_mv, exp_blk, done;
    int cnt;
    model_step(d, exp_mv, exp_blk);
    @(negedge clk);
    tick = 1'b1;
    dir = d;
    done = 0;
    cnt = 0;
    while (!done && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        tick = extra;
        dir = extra ? 4'b0001 : d;
      end
      if (cnt == 3) tick = 1'b0;
      if (moved === 1'b1 || blocked === 1'b1) done = 1;
    end
    tick = 1'b0;
    lat = cnt;
    check("move_done", 32'(done), 32'd1);
    check("moved", 32'(moved), 32'(exp_mv));
    check("blocked", 32'(blocked), 32'(exp_blk));
    check_pos("move");
    @(negedge clk);
    check("pulse_len", {30'd0, moved, blocked}, 32'd0);
  endtask

  task automatic do_invalid();
    logic [3:0] d;
    d = 4'($urandom_range(0, 15));
    while ($countones(d) == 1) d = 4'($urandom_range(0, 15));
    @(negedge clk);
    tick = 1'b1;
    dir = d;
    @(negedge clk);
    tick = 1'b0;
    check("invalid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_pos("invalid");
  endtask

  task automatic do_home(input bit use_restart);
    @(negedge clk);
    if (use_restart) level_restart = 1'b1;
    else home = 1'b1;
    @(negedge clk);
    level_restart = 1'b0;
    home = 1'b0;
    mx = HOME_X;
    my = HOME_Y;
    check_pos("home");
  endtask

  task automatic clear_map();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        wall_map[r][c] = 4'h0;
  endtask

  int lat, base, cnt;

  initial begin
    rst = 1'b0; tick = 1'b0; dir = 4'h0; home = 1'b0; level_restart = 1'b0;
    tile_w = 10'd40; tile_h = 10'd40; num_rows = 5'd12; num_cols = 5'd16; wall_margin = 10'd0;
    clear_map();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pos_x", 32'(pos_x), 32'd394);
    check("rst_pos_y", 32'(pos_y), 32'd41);
    check("rst_row", 32'(cur_row), 32'd0);
    check("rst_col", 32'(cur_col), 32'd9);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(wall_req), 32'd0);
    check("rst_pulses", {30'd0, moved, blocked}, 32'd0);

    // level with taller tiles so the home y offset lies inside tile row 0
    tile_h = 10'd48;
    do_home(1'b1);

    // free moves and tile crossing
    ack_delay = 0;
    do_move(4'b0100, 1'b0, lat);
    check("latency", 32'(lat), 32'd4);
    check("free_x", 32'(pos_x), 32'd396);
    do_move(4'b0100, 1'b0, lat);
    do_move(4'b0100, 1'b0, lat);
    check("cross_col", 32'(cur_col), 32'd10);
    check("cross_x", 32'(pos_x), 32'd400);

    // right wall with margin: blocked at x_off 26, free at x_off 24
    do_home(1'b0);
    wall_map[0][9] = 4'b0001;
    wall_margin = 10'd4;
    repeat (4) do_move(4'b0010, 1'b0, lat);
    do_move(4'b0100, 1'b0, lat);
    check("wall_x_hold", 32'(pos_x), 32'd386);
    do_move(4'b0010, 1'b0, lat);
    do_move(4'b0100, 1'b0, lat);
    check("wall_x_free", 32'(pos_x), 32'd386);

    // walk to the west grid edge, then try to leave it with a slow ack
    clear_map();
    wall_margin = 10'd0;
    do_home(1'b0);
    while (mx > 0) do_move(4'b0010, 1'b0, lat);
    ack_delay = 5;
    max_age = 0;
    base = n_req;
    do_move(4'b0010, 1'b0, lat);
    check("edge_nreq", 32'(n_req - base), 32'd1);
    check("slow_ack_age", 32'(max_age), 32'd5);
    check("edge_x", 32'(pos_x), 32'd0);

    // abort during the adjacent lookup
    do_home(1'b0);
    ack_delay = 20;
    base = n_req;
    @(negedge clk);
    tick = 1'b1;
    dir = 4'b0100;
    @(negedge clk);
    tick = 1'b0;
    cnt = 0;
    while ((n_req - base) < 2 && cnt < 100) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("abort_reach_adj", 32'(n_req - base), 32'd2);
    level_restart = 1'b1;
    @(negedge clk);
    level_restart = 1'b0;
    check("abort_req", 32'(wall_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check_pos("abort");

    // ticks while busy are dropped
    ack_delay = 3;
    do_move(4'b0100, 1'b1, lat);
    repeat (10) @(negedge clk);
    check("no_queue_busy", 32'(busy), 32'd0);
    check_pos("no_queue");

    // random walls, directions, margins and ack delays
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 16; c++)
        wall_map[r][c] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    do_home(1'b1);
    for (int i = 0; i < 250; i++) begin
      int sel;
      ack_delay = $urandom_range(0, 3);
      wall_margin = 10'($urandom_range(0, 6));
      sel = $urandom_range(0, 19);
      if (sel == 0) do_home(1'b0);
      else if (sel < 3) do_invalid();
      else do_move(4'(1 << $urandom_range(0, 3)), 1'b0, lat);
    end

    repeat (5) @(negedge clk);
    check("moved_count", 32'(n_moved_seen), 32'(n_moved_exp));
    check("addr_in_grid", 32'(bad_addr), 32'd0);
    check("addr_stable", 32'(addr_moves), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
